vga_draw_sequencer: RTL

Owns the single VGA adapter pixel-write port (160x120, 3-bit RGB) and shares it between three full-screen drawing engines: start screen, game screen and game-over screen. It grants one engine at a time and starts it with a held enable. It muxes the granted engine's pixel stream onto the VGA port, waits for the engine's done flag, and reports completion or timeout to the game FSM. It sits between the top-level game FSM and the per-screen draw blocks.

---
 rtl/vga_draw_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vga_draw_sequencer.sv
// Shares the 160x120 VGA pixel-write port between three full-screen draw engines.
// Optional macro VGA_CLIP_EN suppresses VGA_plot for pixels outside X_MAX/Y_MAX.
module vga_draw_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned X_MAX          = 159,
   parameter int unsigned Y_MAX          = 119
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic        clr_err,
   input  logic [8:0]  eng_colour,
   input  logic [23:0] eng_x,
   input  logic [20:0] eng_y,
   input  logic [2:0]  eng_done,
   output logic [2:0]  grant,
   output logic [2:0]  VGA_Colour,
   output logic [7:0]  VGA_x,
   output logic [6:0]  VGA_y,
   output logic        VGA_plot,
   output logic        busy,
   output logic [2:0]  done_pulse,
   output logic        timeout_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
`ifdef VGA_CLIP_EN
   localparam logic CLIP_EN = 1'b1;
`else
   localparam logic CLIP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_sel, w_sel_nxt, w_req_sel;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_grant, w_grant_nxt;
   logic [2:0]       r_colour, w_colour_nxt;
   logic [7:0]       r_x, w_x_nxt;
   logic [6:0]       r_y, w_y_nxt;
   logic             r_plot, w_plot_nxt;
   logic             r_busy, w_busy_nxt;
   logic [2:0]       r_done, w_done_nxt;
   logic             r_err, w_err_nxt;

   logic [2:0]       w_eng_colour;
   logic [7:0]       w_eng_x;
   logic [6:0]       w_eng_y;
   logic             w_eng_done;
   logic             w_in_bounds;

   // Fixed priority: game-over > start screen > game screen
   always_comb begin
      w_req_sel = 2'd1;
      if (req[0]) w_req_sel = 2'd0;
      if (req[2]) w_req_sel = 2'd2;
   end

   // Granted engine's pixel slice
   always_comb begin
      w_eng_colour = eng_colour[2:0];
      w_eng_x      = eng_x[7:0];
      w_eng_y      = eng_y[6:0];
      w_eng_done   = eng_done[0];
      case (r_sel)
         2'd1: begin
            w_eng_colour = eng_colour[5:3];
            w_eng_x      = eng_x[15:8];
            w_eng_y      = eng_y[13:7];
            w_eng_done   = eng_done[1];
         end
         2'd2: begin
            w_eng_colour = eng_colour[8:6];
            w_eng_x      = eng_x[23:16];
            w_eng_y      = eng_y[20:14];
            w_eng_done   = eng_done[2];
         end
         default: ;
      endcase
   end

   assign w_in_bounds = !CLIP_EN || ((w_eng_x <= 8'(X_MAX)) && (w_eng_y <= 7'(Y_MAX)));

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel;
      w_cnt_nxt    = r_cnt;
      w_grant_nxt  = r_grant;
      w_colour_nxt = r_colour;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_plot_nxt   = 1'b0;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 3'b000;
      w_err_nxt    = r_err & ~clr_err;
      case (r_state)
         S_IDLE: begin
            w_grant_nxt = 3'b000;
            w_busy_nxt  = 1'b0;
            if (req != 3'b000) begin
               w_sel_nxt   = w_req_sel;
               w_grant_nxt = 3'b001 << w_req_sel;
               w_busy_nxt  = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_DRAW;
            end
         end
         S_DRAW: begin
            w_colour_nxt = w_eng_colour;
            w_x_nxt      = w_eng_x;
            w_y_nxt      = w_eng_y;
            w_cnt_nxt    = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
            if (w_eng_done) begin
               w_plot_nxt  = w_in_bounds;
               w_grant_nxt = 3'b000;
               w_done_nxt  = 3'b001 << r_sel;
               w_state_nxt = S_FINISH;
            end else if (r_cnt == CNT_LAST) begin
               w_grant_nxt = 3'b000;
               w_busy_nxt  = 1'b0;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_plot_nxt = w_in_bounds;
            end
         end
         S_FINISH: begin
            w_grant_nxt = 3'b000;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_grant_nxt = 3'b000;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_sel    <= 2'd0;
         r_cnt    <= '0;
         r_grant  <= 3'b000;
         r_colour <= 3'b000;
         r_x      <= 8'd0;
         r_y      <= 7'd0;
         r_plot   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 3'b000;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_cnt    <= w_cnt_nxt;
         r_grant  <= w_grant_nxt;
         r_colour <= w_colour_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_plot   <= w_plot_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign grant       = r_grant;
   assign VGA_Colour  = r_colour;
   assign VGA_x       = r_x;
   assign VGA_y       = r_y;
   assign VGA_plot    = r_plot;
   assign busy        = r_busy;
   assign done_pulse  = r_done;
   assign timeout_err = r_err;

endmodule
